// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Word fetches only; any low address bit set is an unusable target.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, instruction memory, execute redirect and decode.
interface fetch_sequencer_if;

    logic [fetch_pkg::XLEN-1:0] imem_addr;
    logic [fetch_pkg::XLEN-1:0] imem_rdata;
    logic                       redirect_valid;
    logic [fetch_pkg::XLEN-1:0] redirect_pc;
    logic                       halt;
    logic                       out_valid;
    logic                       out_ready;
    logic [fetch_pkg::XLEN-1:0] out_instr;
    logic [fetch_pkg::XLEN-1:0] out_pc;
    logic                       fault;
    logic [fetch_pkg::XLEN-1:0] perf_fetch_cnt;
    logic [fetch_pkg::XLEN-1:0] perf_stall_cnt;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  halt,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        output fault,
        output perf_fetch_cnt,
        output perf_stall_cnt
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output halt,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        input  fault,
        input  perf_fetch_cnt,
        input  perf_stall_cnt
    );

endinterface

// File: rtl/fetch_fifo.sv
// Shift-style fetch buffer: entry 0 is always the head, so head data and valid come straight from flops.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    fetch_entry_t               ent_q [BUF_DEPTH];
    fetch_entry_t               ent_d [BUF_DEPTH];
    logic [BUF_DEPTH-1:0]       vld_q;
    logic [BUF_DEPTH-1:0]       vld_d;
    logic                       placed;

    assign full  = vld_q[BUF_DEPTH-1];
    assign empty = ~vld_q[0];
    assign head  = ent_q[0];

    // Flush wins over push; a pop in the flush cycle is simply lost with the rest.
    always_comb begin
        ent_d  = ent_q;
        vld_d  = vld_q;
        placed = 1'b0;
        if (flush) begin
            vld_d = '0;
        end else begin
            if (pop && vld_q[0]) begin
                for (int i = 0; i < int'(BUF_DEPTH) - 1; i++) begin
                    ent_d[i] = ent_q[i+1];
                end
                vld_d = {1'b0, vld_q[BUF_DEPTH-1:1]};
            end
            if (push) begin
                for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                    if (!placed && !vld_d[i]) begin
                        ent_d[i] = push_data;
                        vld_d[i] = 1'b1;
                        placed   = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '{default: '0};
            vld_q <= '0;
        end else begin
            ent_q <= ent_d;
            vld_q <= vld_d;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, absorbs redirects, buffers {pc, instr} for decode.
// Optional performance counters are built only when FETCH_PERF_EN is defined.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input logic                clk,
    input logic                reset,
    fetch_sequencer_if.master  bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;

    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_flush;
    logic            enqueue;
    logic            pop;
    fetch_entry_t    fifo_head;
    fetch_entry_t    push_data;

    assign pop       = ~fifo_empty & bus.out_ready;
    assign push_data = '{pc: pc_q, instr: bus.imem_rdata};

    // Next-state, PC and buffer control.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_d    = fault_q;
        fifo_flush = 1'b0;
        enqueue    = 1'b0;
        case (state_q)
            FETCH, HALTED: begin
                if (bus.redirect_valid) begin
                    fifo_flush = 1'b1;
                    if (is_misaligned(bus.redirect_pc[1:0])) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = bus.redirect_pc;
                        state_d = bus.halt ? HALTED : FETCH;
                    end
                end else begin
                    state_d = bus.halt ? HALTED : FETCH;
                    if ((state_q == FETCH) && !bus.halt && (!fifo_full || pop)) begin
                        enqueue = 1'b1;
                        pc_d    = pc_q + PC_INC;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (enqueue),
        .push_data (push_data),
        .pop       (pop),
        .flush     (fifo_flush),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = ~fifo_empty;
    assign bus.out_pc    = fifo_head.pc;
    assign bus.out_instr = fifo_head.instr;
    assign bus.fault     = fault_q;

`ifdef FETCH_PERF_EN
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [XLEN-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters; only reset clears them.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (enqueue && (fetch_cnt_q != '1)) begin
            fetch_cnt_d = fetch_cnt_q + XLEN'(1);
        end
        if (!fifo_empty && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.perf_fetch_cnt = fetch_cnt_q;
    assign bus.perf_stall_cnt = stall_cnt_q;
`else
    assign bus.perf_fetch_cnt = '0;
    assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised, self-checking bench for fetch_sequencer against a queue-based reference model.
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    logic [31:0] mem [256];
    exp_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_fault;
    logic [31:0] m_fetch;
    logic [31:0] m_stall;

    fetch_sequencer_if bus();

    fetch_sequencer #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.imem_rdata = mem[bus.imem_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_perf(input logic [31:0] v);
`ifdef FETCH_PERF_EN
        return v;
`else
        return (v & 32'd0);
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc     = RST_PC;
        m_halted = 1'b0;
        m_fault  = 1'b0;
        m_fetch  = 32'd0;
        m_stall  = 32'd0;
    endtask

    // One clock edge of the architectural behaviour, using the inputs currently driven.
    task automatic model_step();
        bit   pop;
        bit   was_full;
        exp_t e;
        pop      = (mq.size() != 0) && bus.out_ready;
        was_full = (mq.size() >= DEPTH);
        if ((mq.size() != 0) && !bus.out_ready && (m_stall != 32'hFFFF_FFFF)) m_stall++;
        if (m_fault) return;
        if (pop) void'(mq.pop_front());
        if (bus.redirect_valid) begin
            mq.delete();
            if ((bus.redirect_pc % 4) != 0) m_fault = 1'b1;
            else begin
                m_pc     = bus.redirect_pc;
                m_halted = bus.halt;
            end
        end else begin
            if (!m_halted && !bus.halt && (!was_full || pop)) begin
                e.pc    = m_pc;
                e.instr = mem[m_pc[9:2]];
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
                if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
            end
            m_halted = bus.halt;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt           = 1'b0;
        bus.out_ready      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, RST_PC); end
        checks++; if ({bus.out_pc, bus.out_instr} !== 64'd0) begin errors++; $display("FAIL reset_head got=%h/%h exp=0/0", bus.out_pc, bus.out_instr); end
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
        checks++; if ({bus.perf_fetch_cnt, bus.perf_stall_cnt} !== 64'd0) begin errors++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", bus.perf_fetch_cnt, bus.perf_stall_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_sequence();
        logic [31:0] want_instr [3];
        want_instr[0] = 32'h2004_0003;
        want_instr[1] = 32'h0C00_0003;
        want_instr[2] = 32'h1000_FFFF;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k) || bus.out_instr !== want_instr[k]) begin
                errors++;
                $display("FAIL seq_head%0d got=%b/%h/%h exp=1/%h/%h", k, bus.out_valid, bus.out_pc, bus.out_instr, 32'(4 * k), want_instr[k]);
            end
        end
        checks++; if (bus.perf_fetch_cnt !== exp_perf(32'd3)) begin errors++; $display("FAIL seq_perf_fetch got=%0d exp=%0d", bus.perf_fetch_cnt, exp_perf(32'd3)); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k >= 1) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd0 || bus.out_instr !== 32'h2004_0003) begin
                    errors++;
                    $display("FAIL stall_hold%0d got=%b/%h/%h exp=1/0/20040003", k, bus.out_valid, bus.out_pc, bus.out_instr);
                end
            end
        end
        checks++; if (bus.imem_addr !== 32'd8) begin errors++; $display("FAIL stall_addr got=%h exp=8", bus.imem_addr); end
        checks++; if (bus.perf_stall_cnt !== exp_perf(32'd4)) begin errors++; $display("FAIL stall_perf got=%0d exp=%0d", bus.perf_stall_cnt, exp_perf(32'd4)); end
        checks++; if (bus.perf_fetch_cnt !== exp_perf(32'd2)) begin errors++; $display("FAIL stall_fetch got=%0d exp=%0d", bus.perf_fetch_cnt, exp_perf(32'd2)); end
    endtask

    task automatic test_redirect();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_000C;
        cycle();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got=%b exp=0", bus.out_valid); end
        cycle();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0C || bus.out_instr !== 32'h23BD_FFF8) begin
            errors++;
            $display("FAIL redir_target got=%b/%h/%h exp=1/0000000c/23bdfff8", bus.out_valid, bus.out_pc, bus.out_instr);
        end
        cycle();
        checks++; if (bus.out_pc !== 32'h10) begin errors++; $display("FAIL redir_next got=%h exp=00000010", bus.out_pc); end
    endtask

    task automatic test_pop_redirect();
        do_reset();
        repeat (3) cycle();
        checks++; if (bus.out_pc !== 32'd0 || bus.imem_addr !== 32'd8) begin errors++; $display("FAIL popredir_full got=%h/%h exp=0/8", bus.out_pc, bus.imem_addr); end
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0010;
        cycle();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL popredir_bubble got=%b exp=0", bus.out_valid); end
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(32'h10 + 4 * k)) begin
                errors++;
                $display("FAIL popredir_seq%0d got=%b/%h exp=1/%h", k, bus.out_valid, bus.out_pc, 32'(32'h10 + 4 * k));
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        repeat (2) cycle();
        bus.halt      = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd4) begin errors++; $display("FAIL halt_drain got=%b/%h exp=1/4", bus.out_valid, bus.out_pc); end
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'd8) begin
                errors++;
                $display("FAIL halt_idle%0d got=%b/%h exp=0/8", k, bus.out_valid, bus.imem_addr);
            end
        end
        bus.halt = 1'b0;
        begin
            int budget;
            budget = 0;
            while (bus.out_valid !== 1'b1 && budget < 4) begin cycle(); budget++; end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'd8) begin errors++; $display("FAIL halt_resume got=%b/%h exp=1/8", bus.out_valid, bus.out_pc); end
        end
        // Redirect together with halt: target taken, sequencer parks until halt drops.
        bus.halt           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0040;
        cycle();
        bus.redirect_valid = 1'b0;
        repeat (2) cycle();
        checks++; if (bus.out_valid !== 1'b0 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL halt_redir got=%b/%h exp=0/40", bus.out_valid, bus.imem_addr); end
        bus.halt = 1'b0;
        repeat (2) cycle();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40) begin errors++; $display("FAIL halt_redir_resume got=%b/%h exp=1/40", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF8;
        cycle();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            checks++;
            if (bus.out_pc !== 32'(32'hFFFF_FFF8 + 4 * k) || bus.out_instr !== mq[0].instr) begin
                errors++;
                $display("FAIL wrap%0d got=%h/%h exp=%h/%h", k, bus.out_pc, bus.out_instr, 32'(32'hFFFF_FFF8 + 4 * k), mq[0].instr);
            end
        end
    endtask

    task automatic test_fault();
        do_reset();
        bus.out_ready = 1'b1;
        repeat (2) cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0006;
        cycle();
        checks++; if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'd8) begin errors++; $display("FAIL fault_set got=%b/%b/%h exp=1/0/8", bus.fault, bus.out_valid, bus.imem_addr); end
        bus.redirect_pc = 32'h0000_0020;
        cycle();
        bus.redirect_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            checks++;
            if (bus.fault !== 1'b1 || bus.out_valid !== 1'b0 || bus.imem_addr !== 32'd8) begin
                errors++;
                $display("FAIL fault_hold%0d got=%b/%b/%h exp=1/0/8", k, bus.fault, bus.out_valid, bus.imem_addr);
            end
        end
        do_reset();
        checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b exp=0", bus.fault); end
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (3) cycle();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.imem_addr !== RST_PC || bus.out_pc !== 32'd0 || bus.out_instr !== 32'd0 ||
            bus.perf_fetch_cnt !== 32'd0 || bus.perf_stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got=%b/%h/%h/%h/%0d/%0d exp=0/%h/0/0/0/0", bus.out_valid, bus.imem_addr,
                     bus.out_pc, bus.out_instr, bus.perf_fetch_cnt, bus.perf_stall_cnt, RST_PC);
        end
        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            checks++; if (bus.out_valid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.out_valid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++;
                if (bus.out_pc !== mq[0].pc || bus.out_instr !== mq[0].instr) begin
                    errors++;
                    $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h", c, bus.out_pc, bus.out_instr, mq[0].pc, mq[0].instr);
                end
            end
            checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, bus.imem_addr, m_pc); end
            checks++; if (bus.fault !== m_fault) begin errors++; $display("FAIL rnd_fault c=%0d got=%b exp=%b", c, bus.fault, m_fault); end
            checks++;
            if (bus.perf_fetch_cnt !== exp_perf(m_fetch) || bus.perf_stall_cnt !== exp_perf(m_stall)) begin
                errors++;
                $display("FAIL rnd_perf c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.perf_fetch_cnt, bus.perf_stall_cnt, exp_perf(m_fetch), exp_perf(m_stall));
            end
            if (m_fault && $urandom_range(0, 7) == 0) begin
                do_reset();
                continue;
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) bus.halt = ~bus.halt;
            r = int'($urandom_range(0, 99));
            bus.redirect_valid = (r < 6);
            if (r == 0 && $urandom_range(0, 3) == 0) bus.redirect_pc = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (r == 1) bus.redirect_pc = 32'hFFFF_FFF0 + {28'd0, 2'($urandom), 2'b00};
            else bus.redirect_pc = {22'd0, 8'($urandom), 2'b00};
            cycle();
        end
        idle_inputs();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h2004_0003;
        mem[1] = 32'h0C00_0003;
        mem[2] = 32'h1000_FFFF;
        mem[3] = 32'h23BD_FFF8;
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_pop_redirect();
        test_halt();
        test_wrap();
        test_fault();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
